// File: rtl/dtree_pkg.sv
// Shared definitions for the decision-tree traversal controller: state encoding
// and node-word field layout helpers.
package dtree_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_STREAM,
        S_WAIT_DIR,
        S_DONE
    } state_t;

    function automatic int node_count(input int max_depth);
        return (1 << max_depth) - 1;
    endfunction

    function automatic int addr_w(input int max_depth);
        return $clog2(node_count(max_depth));
    endfunction

    function automatic int node_w(input int features, input int cbd, input int bbd);
        return 2 + features + (features - 1) * cbd + bbd;
    endfunction

    // Node word: {flags[1:0], one_pos[F-1:0], coeff 0 .. coeff F-2, bias}
    function automatic int bias_lsb();
        return 0;
    endfunction

    function automatic int coeff_lsb(input int features, input int cbd, input int bbd,
                                     input int k);
        return bbd + (features - 2 - k) * cbd;
    endfunction

    function automatic int one_pos_lsb(input int features, input int cbd, input int bbd);
        return bbd + (features - 1) * cbd;
    endfunction

    function automatic int flags_lsb(input int features, input int cbd, input int bbd);
        return one_pos_lsb(features, cbd, bbd) + features;
    endfunction

endpackage

// File: rtl/dtree_node_ram.sv
// Node table: one synchronous write port, one asynchronous read port.
module dtree_node_ram #(
    parameter int DEPTH  = 15,
    parameter int WIDTH  = 23,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dtree_traverse_ctrl.sv
// Per-spike decision-tree walker: streams node coefficients to the dot-product
// datapath and follows branch decisions. Optional DTREE_TRAVERSE_PERF_EN adds perf counters.
//
// state      | meaning
// S_IDLE     | table writable, waiting for start
// S_FETCH    | latch node word from table
// S_STREAM   | coefficient beats 0..FEATURES-1 under valid/ready
// S_WAIT_DIR | waiting for the branch decision
// S_DONE     | result held until res_ready
module dtree_traverse_ctrl
    import dtree_pkg::*;
#(
    parameter int FEATURES        = 3,
    parameter int COEFF_BIT_DEPTH = 4,
    parameter int BIAS_BIT_DEPTH  = 10,
    parameter int MAX_DEPTH       = 4
) (
    input  logic                                                   clk,
    input  logic                                                   reset,
    input  logic                                                   start,
    output logic                                                   busy,
    input  logic                                                   cfg_we,
    input  logic [addr_w(MAX_DEPTH)-1:0]                           cfg_addr,
    input  logic [node_w(FEATURES,COEFF_BIT_DEPTH,BIAS_BIT_DEPTH)-1:0] cfg_wdata,
    output logic                                                   coeff_valid,
    input  logic                                                   coeff_ready,
    output logic [COEFF_BIT_DEPTH-1:0]                             coeff,
    output logic                                                   is_one,
    output logic                                                   coeff_last,
    output logic [BIAS_BIT_DEPTH-1:0]                              bias,
    input  logic                                                   dir_valid,
    input  logic                                                   dir,
    output logic                                                   res_valid,
    input  logic                                                   res_ready,
    output logic [addr_w(MAX_DEPTH)-1:0]                           leaf_index,
    output logic [$clog2(MAX_DEPTH+1)-1:0]                         level,
    output logic [MAX_DEPTH-1:0]                                   path
`ifdef DTREE_TRAVERSE_PERF_EN
    ,
    output logic [15:0]                                            perf_nodes,
    output logic [15:0]                                            perf_stall
`endif
);

    localparam int NODES     = node_count(MAX_DEPTH);
    localparam int ADDR_W    = addr_w(MAX_DEPTH);
    localparam int NODE_W    = node_w(FEATURES, COEFF_BIT_DEPTH, BIAS_BIT_DEPTH);
    localparam int LEVEL_W   = $clog2(MAX_DEPTH + 1);
    localparam int BEAT_W    = $clog2(FEATURES + 1);
    localparam int ONE_LSB   = one_pos_lsb(FEATURES, COEFF_BIT_DEPTH, BIAS_BIT_DEPTH);
    localparam int FLAGS_LSB = flags_lsb(FEATURES, COEFF_BIT_DEPTH, BIAS_BIT_DEPTH);

    state_t              state;
    logic [ADDR_W-1:0]   node;
    logic [ADDR_W-1:0]   child;
    logic                child_ok;
    logic [NODE_W-1:0]   node_word;
    logic [NODE_W-1:0]   rd_data;
    logic [BEAT_W-1:0]   beat;
    logic [BEAT_W-1:0]   cidx;
    logic                table_we;

    logic [NODE_W-1:0]          src_word;
    logic [BEAT_W-1:0]          src_k;
    logic [BEAT_W-1:0]          src_c;
    logic [BEAT_W-1:0]          unit_k;
    logic                       unit_hit;
    logic [FEATURES-1:0]        one_v;
    logic                       nxt_is_one;
    logic [COEFF_BIT_DEPTH-1:0] nxt_coeff;

    assign table_we = cfg_we && (state == S_IDLE) && (int'(cfg_addr) < NODES);

    dtree_node_ram #(
        .DEPTH  (NODES),
        .WIDTH  (NODE_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (table_we),
        .waddr (cfg_addr),
        .wdata (cfg_wdata),
        .raddr (node),
        .rdata (rd_data)
    );

    assign bias     = node_word[bias_lsb() +: BIAS_BIT_DEPTH];
    assign child    = {node[ADDR_W-2:0], 1'b0} + ADDR_W'(1) + ADDR_W'(dir);
    assign child_ok = dir ? node_word[FLAGS_LSB] : node_word[FLAGS_LSB+1];

    // Next beat: from the table read in FETCH, from the latched word in STREAM.
    always_comb begin
        src_word = (state == S_FETCH) ? rd_data : node_word;
        src_k    = (state == S_FETCH) ? '0 : beat + BEAT_W'(1);
        src_c    = (state == S_FETCH) ? '0 : (is_one ? cidx : cidx + BEAT_W'(1));
        one_v    = src_word[ONE_LSB +: FEATURES];
        unit_hit = 1'b0;
        unit_k   = '0;
        for (int j = 0; j < FEATURES; j++) begin
            if (!unit_hit && one_v[FEATURES-1-j]) begin
                unit_hit = 1'b1;
                unit_k   = BEAT_W'(j);
            end
        end
        nxt_is_one = unit_hit && (unit_k == src_k);
        nxt_coeff  = '0;
        if (!nxt_is_one) begin
            for (int j = 0; j < FEATURES - 1; j++) begin
                if (src_c == BEAT_W'(j))
                    nxt_coeff = src_word[coeff_lsb(FEATURES, COEFF_BIT_DEPTH,
                                                   BIAS_BIT_DEPTH, j) +: COEFF_BIT_DEPTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            node        <= '0;
            node_word   <= '0;
            beat        <= '0;
            cidx        <= '0;
            busy        <= 1'b0;
            coeff_valid <= 1'b0;
            coeff       <= '0;
            is_one      <= 1'b0;
            coeff_last  <= 1'b0;
            res_valid   <= 1'b0;
            leaf_index  <= '0;
            level       <= '0;
            path        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        node  <= '0;
                        level <= '0;
                        path  <= '0;
                        busy  <= 1'b1;
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    node_word   <= rd_data;
                    beat        <= '0;
                    cidx        <= '0;
                    coeff_valid <= 1'b1;
                    coeff       <= nxt_coeff;
                    is_one      <= nxt_is_one;
                    coeff_last  <= 1'b0;
                    state       <= S_STREAM;
                end
                S_STREAM: begin
                    if (coeff_valid && coeff_ready) begin
                        if (coeff_last) begin
                            coeff_valid <= 1'b0;
                            coeff       <= '0;
                            is_one      <= 1'b0;
                            coeff_last  <= 1'b0;
                            state       <= S_WAIT_DIR;
                        end else begin
                            beat       <= src_k;
                            cidx       <= src_c;
                            coeff      <= nxt_coeff;
                            is_one     <= nxt_is_one;
                            coeff_last <= (src_k == BEAT_W'(FEATURES - 1));
                        end
                    end
                end
                S_WAIT_DIR: begin
                    if (dir_valid) begin
                        for (int j = 0; j < MAX_DEPTH; j++) begin
                            if (level == LEVEL_W'(j)) path[j] <= dir;
                        end
                        level <= level + LEVEL_W'(1);
                        if (!child_ok || level == LEVEL_W'(MAX_DEPTH - 1)) begin
                            leaf_index <= node;
                            res_valid  <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            node  <= child;
                            state <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef DTREE_TRAVERSE_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_nodes <= '0;
            perf_stall <= '0;
        end else begin
            if (state == S_FETCH && perf_nodes != 16'hFFFF)
                perf_nodes <= perf_nodes + 16'd1;
            if (state == S_STREAM && coeff_valid && !coeff_ready && perf_stall != 16'hFFFF)
                perf_stall <= perf_stall + 16'd1;
        end
    end
`endif

endmodule
